// File: rtl/ycbcr_to_rgb565_if.sv
// Video stream bundle for the YCbCr-to-RGB565 converter.
//   pre_frame_*  : input sync qualifiers (vsync, hsync, de)
//   img_y/cb/cr  : 8-bit full-range BT.601 samples, valid while pre_frame_de=1
//   post_frame_* : sync qualifiers delayed to line up with the pixel outputs
//   rgb565_data  : packed pixel {B5, G6, R5}
//   rgb_r8/g8/b8 : clamped 8-bit components ahead of the 565 truncation
// master drives the YCbCr side; slave is the converter.
interface ycbcr_to_rgb565_if;
  logic        pre_frame_vsync;
  logic        pre_frame_hsync;
  logic        pre_frame_de;
  logic [7:0]  img_y;
  logic [7:0]  img_cb;
  logic [7:0]  img_cr;

  logic        post_frame_vsync;
  logic        post_frame_hsync;
  logic        post_frame_de;
  logic [15:0] rgb565_data;
  logic [7:0]  rgb_r8;
  logic [7:0]  rgb_g8;
  logic [7:0]  rgb_b8;

  modport master (
    output pre_frame_vsync, pre_frame_hsync, pre_frame_de,
    output img_y, img_cb, img_cr,
    input  post_frame_vsync, post_frame_hsync, post_frame_de,
    input  rgb565_data, rgb_r8, rgb_g8, rgb_b8
  );

  modport slave (
    input  pre_frame_vsync, pre_frame_hsync, pre_frame_de,
    input  img_y, img_cb, img_cr,
    output post_frame_vsync, post_frame_hsync, post_frame_de,
    output rgb565_data, rgb_r8, rgb_g8, rgb_b8
  );
endinterface

// File: rtl/ycbcr_to_rgb565.sv
// Streaming full-range BT.601 YCbCr to RGB565 converter.
// Fixed 3-stage pipeline with no back-pressure; syncs ride a matching
// 3-deep delay line. Outputs are forced to 0 while post_frame_de=0.
//   clk   : pixel clock, rising edge
//   rst_n : asynchronous active-low reset
//   vid   : video stream bundle (slave side)
// ROUND=1 adds one half LSB before the final >>8 (round-half-up).
module ycbcr_to_rgb565 #(
  parameter bit ROUND = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  ycbcr_to_rgb565_if.slave   vid
);

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned CHR_W   = 9;
  localparam int unsigned SUM_W   = 19;
  localparam int unsigned DLY     = 3;
  localparam int unsigned RGB565W = 16;

  // Q8 coefficients
  localparam logic signed [SUM_W-1:0] K_CR_R = SUM_W'(359);
  localparam logic signed [SUM_W-1:0] K_CB_G = SUM_W'(88);
  localparam logic signed [SUM_W-1:0] K_CR_G = SUM_W'(183);
  localparam logic signed [SUM_W-1:0] K_CB_B = SUM_W'(454);

  localparam logic signed [SUM_W-1:0] RND_ADD = ROUND ? SUM_W'(128) : SUM_W'(0);
  localparam logic signed [SUM_W-1:0] MAX8    = SUM_W'(255);

  function automatic logic signed [SUM_W-1:0] sext_chroma(input logic signed [CHR_W-1:0] x);
    return $signed({{(SUM_W-CHR_W){x[CHR_W-1]}}, x});
  endfunction

  // Round/shift a Q8 sum back to pixel scale and saturate to 0..255
  function automatic logic [PIX_W-1:0] clamp8(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] t;
    t = (s + RND_ADD) >>> 8;
    if (t < 0)         return '0;
    else if (t > MAX8) return '1;
    else               return t[PIX_W-1:0];
  endfunction

  // Stage 1: centre chroma, scale luma, form products
  logic signed [CHR_W-1:0] cbs_c, crs_c;
  logic signed [SUM_W-1:0] ys_c, pr_c, pgb_c, pgr_c, pb_c;

  always_comb begin
    cbs_c = $signed({1'b0, vid.img_cb}) - 9'sd128;
    crs_c = $signed({1'b0, vid.img_cr}) - 9'sd128;
    ys_c  = $signed({3'b000, vid.img_y, 8'h00});
    pr_c  = sext_chroma(crs_c) * K_CR_R;
    pgb_c = sext_chroma(cbs_c) * K_CB_G;
    pgr_c = sext_chroma(crs_c) * K_CR_G;
    pb_c  = sext_chroma(cbs_c) * K_CB_B;
  end

  logic signed [SUM_W-1:0] ys_q, pr_q, pgb_q, pgr_q, pb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ys_q  <= '0;
      pr_q  <= '0;
      pgb_q <= '0;
      pgr_q <= '0;
      pb_q  <= '0;
    end else begin
      ys_q  <= ys_c;
      pr_q  <= pr_c;
      pgb_q <= pgb_c;
      pgr_q <= pgr_c;
      pb_q  <= pb_c;
    end
  end

  // Stage 2: per-channel sums; 19 bits covers every 8-bit input combination
  logic signed [SUM_W-1:0] sr_q, sg_q, sb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
      sg_q <= '0;
      sb_q <= '0;
    end else begin
      sr_q <= ys_q + pr_q;
      sg_q <= ys_q - pgb_q - pgr_q;
      sb_q <= ys_q + pb_q;
    end
  end

  // Sync delay lines; bit [1] is the de belonging to the pixel in stage 2
  logic [DLY-1:0] vs_q, hs_q, de_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= '0;
      hs_q <= '0;
      de_q <= '0;
    end else begin
      vs_q <= {vs_q[DLY-2:0], vid.pre_frame_vsync};
      hs_q <= {hs_q[DLY-2:0], vid.pre_frame_hsync};
      de_q <= {de_q[DLY-2:0], vid.pre_frame_de};
    end
  end

  // Stage 3: clamp, pack, and mask with the pixel's own de
  logic [PIX_W-1:0] r8_c, g8_c, b8_c;

  always_comb begin
    r8_c = clamp8(sr_q);
    g8_c = clamp8(sg_q);
    b8_c = clamp8(sb_q);
  end

  logic [PIX_W-1:0]   r8_q, g8_q, b8_q;
  logic [RGB565W-1:0] rgb565_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r8_q     <= '0;
      g8_q     <= '0;
      b8_q     <= '0;
      rgb565_q <= '0;
    end else if (de_q[DLY-2]) begin
      r8_q     <= r8_c;
      g8_q     <= g8_c;
      b8_q     <= b8_c;
      rgb565_q <= {b8_c[7:3], g8_c[7:2], r8_c[7:3]};
    end else begin
      r8_q     <= '0;
      g8_q     <= '0;
      b8_q     <= '0;
      rgb565_q <= '0;
    end
  end

  assign vid.post_frame_vsync = vs_q[DLY-1];
  assign vid.post_frame_hsync = hs_q[DLY-1];
  assign vid.post_frame_de    = de_q[DLY-1];
  assign vid.rgb565_data      = rgb565_q;
  assign vid.rgb_r8           = r8_q;
  assign vid.rgb_g8           = g8_q;
  assign vid.rgb_b8           = b8_q;

endmodule
